// File: rtl/row_feeder.sv
// -----------------------------------------------------------------------------
// row_feeder
//
// Memory-side front end for the edge-detection accelerator. It owns the only
// frame-memory port. It prefetches the input frame into a three-row circular
// buffer and serves each accelerator read beat with three vertically aligned
// words (previous / current / next row). It also commits accelerator write
// beats into the output frame region.
//
// Optional feature macro: ROW_FEEDER_PERF_EN
//   When it is defined, the block adds output stream_cycles[15:0]. This counter
//   is cleared on PREFILL entry, counts STREAM cycles, saturates at 0xFFFF and
//   holds afterwards.
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   start / finish       host handshake: start is a level; finish holds until
//                        start falls
//   row_cached           buffers primed; read beats are accepted (STREAM only)
//   acc_en, acc_we       accelerator beat strobe and beat type (1 = write)
//   dataRa/Rb/Rc         registered previous / current / next row word
//   dataW                write-beat payload
//   mem_addr/en/we       memory command, combinational from state and beat
//   mem_dataR            read data, valid the cycle after a read strobe
//   mem_dataW            write data (dataW during a committed write)
// -----------------------------------------------------------------------------
module row_feeder #(
    parameter int WIDTH       = 352,
    parameter int HEIGHT      = 288,
    parameter int OUT_BASE    = 25344,
    parameter int DROP_WRITES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        finish,
    output logic        row_cached,
    input  logic        acc_en,
    input  logic        acc_we,
    output logic [31:0] dataRa,
    output logic [31:0] dataRb,
    output logic [31:0] dataRc,
    input  logic [31:0] dataW,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    input  logic [31:0] mem_dataR,
    output logic [31:0] mem_dataW
`ifdef ROW_FEEDER_PERF_EN
    ,
    output logic [15:0] stream_cycles
`endif
);

    localparam int ROW_WIDTH   = WIDTH / 4;
    localparam int FRAME_WORDS = ROW_WIDTH * HEIGHT;
    localparam int RB          = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CB          = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;

    localparam logic [15:0]   L_RW2      = 16'(2 * ROW_WIDTH);
    localparam logic [15:0]   L_FW       = 16'(FRAME_WORDS);
    localparam logic [15:0]   L_DROP     = 16'(DROP_WRITES);
    localparam logic [15:0]   L_WMAX     = 16'(DROP_WRITES + FRAME_WORDS);
    localparam logic [15:0]   L_WLAST    = 16'(DROP_WRITES + FRAME_WORDS - 1);
    localparam logic [15:0]   L_OUT_BASE = 16'(OUT_BASE);
    localparam logic [CB-1:0] L_COL_LAST = CB'(ROW_WIDTH - 1);
    localparam logic [RB-1:0] L_ROW_LAST = RB'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_STREAM  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state, w_next;

    // Frame counters
    logic [15:0]   r_n;        // read beats served
    logic [15:0]   r_w;        // write beats seen (saturating)
    logic [15:0]   r_pcnt;     // prefill reads issued
    logic [CB-1:0] r_pcol;     // prefill column
    logic          r_pslot;    // prefill slot (only slots 0 and 1 are primed)
    logic [RB-1:0] r_row;
    logic [CB-1:0] r_col;
    logic [1:0]    r_slot;     // r_row mod 3, tracked incrementally

    // Outstanding read capture: where next cycle's mem_dataR lands
    logic          r_cap_vld;
    logic [1:0]    r_cap_slot;
    logic [CB-1:0] r_cap_col;

    logic [31:0]   r_buf [3][ROW_WIDTH];

    logic          r_finish, r_row_cached;
    logic [31:0]   r_dataRa, r_dataRb, r_dataRc;

    logic          w_enter_pf, w_pf_issue, w_pf_done;
    logic          w_rd_beat, w_rd_live, w_fetch;
    logic          w_wr_beat, w_wr_commit, w_wr_last;
    logic [16:0]   w_fetch_sum;
    logic [1:0]    w_prev_slot, w_next_slot;
    logic [31:0]   w_prev_word, w_cur_word, w_next_word;

    assign finish     = r_finish;
    assign row_cached = r_row_cached;
    assign dataRa     = r_dataRa;
    assign dataRb     = r_dataRb;
    assign dataRc     = r_dataRc;

    // ---------------------------------------------------------------- decode
    assign w_enter_pf  = (r_state == S_IDLE) && start;
    assign w_pf_issue  = (r_state == S_PREFILL) && (r_pcnt < L_RW2);
    // All prefill reads are issued; the last one is captured this cycle
    assign w_pf_done   = (r_state == S_PREFILL) && (r_pcnt == L_RW2);

    assign w_rd_beat   = (r_state == S_STREAM) && acc_en && !acc_we;
    assign w_rd_live   = w_rd_beat && (r_n < L_FW);
    assign w_fetch_sum = {1'b0, r_n} + {1'b0, L_RW2};
    assign w_fetch     = w_rd_live && (w_fetch_sum < {1'b0, L_FW});

    assign w_wr_beat   = (r_state == S_STREAM) && acc_en && acc_we;
    assign w_wr_commit = w_wr_beat && (r_w >= L_DROP) && (r_w < L_WMAX);
    assign w_wr_last   = w_wr_commit && (r_w == L_WLAST);

    // (r+2) mod 3 equals (r-1) mod 3. The refill target is therefore the
    // previous-row slot, which this beat reads before it is overwritten.
    assign w_prev_slot = (r_slot == 2'd0) ? 2'd2 : r_slot - 2'd1;
    assign w_next_slot = (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;

    // A word still in flight from the memory has not reached r_buf yet.
    // Forward it, so that very short rows still see fresh data.
    function automatic logic [31:0] fwd(input logic [1:0]    s,
                                        input logic [CB-1:0] c,
                                        input logic [31:0]   stored,
                                        input logic          cv,
                                        input logic [1:0]    cs,
                                        input logic [CB-1:0] cc,
                                        input logic [31:0]   md);
        return (cv && (cs == s) && (cc == c)) ? md : stored;
    endfunction

    assign w_prev_word = fwd(w_prev_slot, r_col, r_buf[w_prev_slot][r_col],
                             r_cap_vld, r_cap_slot, r_cap_col, mem_dataR);
    assign w_cur_word  = fwd(r_slot, r_col, r_buf[r_slot][r_col],
                             r_cap_vld, r_cap_slot, r_cap_col, mem_dataR);
    assign w_next_word = fwd(w_next_slot, r_col, r_buf[w_next_slot][r_col],
                             r_cap_vld, r_cap_slot, r_cap_col, mem_dataR);

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (start)     w_next = S_PREFILL;
            S_PREFILL: if (w_pf_done) w_next = S_STREAM;
            S_STREAM:  if (w_wr_last) w_next = S_DONE;
            S_DONE:    if (!start)    w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ memory port
    // Prefill, write commits and row refills never overlap in time. Prefill
    // belongs to its own state, and a beat is either a read or a write.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_dataW = '0;
        if (w_pf_issue) begin
            mem_en   = 1'b1;
            mem_addr = r_pcnt;
        end else if (w_wr_commit) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = L_OUT_BASE + r_w - L_DROP;
            mem_dataW = dataW;
        end else if (w_fetch) begin
            mem_en   = 1'b1;
            mem_addr = w_fetch_sum[15:0];
        end
    end

    // ------------------------------------------------------- control datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_finish     <= 1'b0;
            r_row_cached <= 1'b0;
            r_n          <= '0;
            r_w          <= '0;
            r_pcnt       <= '0;
            r_pcol       <= '0;
            r_pslot      <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_slot       <= '0;
            r_cap_vld    <= 1'b0;
            r_cap_slot   <= '0;
            r_cap_col    <= '0;
            r_dataRa     <= '0;
            r_dataRb     <= '0;
            r_dataRc     <= '0;
        end else begin
            r_finish     <= (w_next == S_DONE);
            r_row_cached <= (w_next == S_STREAM);

            if (w_enter_pf) begin
                r_n     <= '0;
                r_w     <= '0;
                r_pcnt  <= '0;
                r_pcol  <= '0;
                r_pslot <= 1'b0;
                r_row   <= '0;
                r_col   <= '0;
                r_slot  <= '0;
            end

            if (w_pf_issue) begin
                r_pcnt <= r_pcnt + 16'd1;
                if (r_pcol == L_COL_LAST) begin
                    r_pcol  <= '0;
                    r_pslot <= 1'b1;
                end else begin
                    r_pcol <= r_pcol + CB'(1);
                end
            end

            r_cap_vld <= w_pf_issue || w_fetch;
            if (w_pf_issue) begin
                r_cap_slot <= {1'b0, r_pslot};
                r_cap_col  <= r_pcol;
            end else if (w_fetch) begin
                r_cap_slot <= w_prev_slot;
                r_cap_col  <= r_col;
            end

            if (w_rd_live) begin
                r_dataRb <= w_cur_word;
                r_dataRa <= (r_row == '0)        ? '0 : w_prev_word;
                r_dataRc <= (r_row == L_ROW_LAST) ? '0 : w_next_word;
                r_n      <= r_n + 16'd1;
                if (r_col == L_COL_LAST) begin
                    r_col  <= '0;
                    r_row  <= r_row + RB'(1);
                    r_slot <= w_next_slot;
                end else begin
                    r_col <= r_col + CB'(1);
                end
            end else if (w_rd_beat) begin
                // Past the end of the frame: the outputs go to zero and n holds
                r_dataRa <= '0;
                r_dataRb <= '0;
                r_dataRc <= '0;
            end

            if (w_wr_beat && (r_w != L_WMAX)) r_w <= r_w + 16'd1;
        end
    end

    // The row buffer is not reset. Stale contents are overwritten by the
    // prefill before any read beat is accepted.
    always_ff @(posedge clk) begin
        if (r_cap_vld) r_buf[r_cap_slot][r_cap_col] <= mem_dataR;
    end

`ifdef ROW_FEEDER_PERF_EN
    logic [15:0] r_stream_cycles;
    assign stream_cycles = r_stream_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stream_cycles <= '0;
        end else if (w_enter_pf) begin
            r_stream_cycles <= '0;
        end else if ((r_state == S_STREAM) && (r_stream_cycles != 16'hFFFF)) begin
            r_stream_cycles <= r_stream_cycles + 16'd1;
        end
    end
`endif

endmodule
